// File: rtl/cam_burst_packer.sv
// Packs an 8-bit camera pixel stream into 32-bit little-endian words, buffers them
// and issues address/length burst requests followed by the beat data.
//
// state | meaning
// IDLE  | waiting for a full burst, a frame-tail flush, or a pending SOF pointer reload
// REQ   | burst request presented, address/length held until accepted
// DATA  | streaming beats of the accepted burst from the FIFO head
module cam_burst_packer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned BURST_BEATS = 16,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        pix_sof,
  input  logic        pix_eol,
  input  logic        pix_eof,
  output logic        pix_ready,
  output logic        bq_valid,
  input  logic        bq_ready,
  output logic [31:0] bq_addr,
  output logic [7:0]  bq_len,
  output logic        wd_valid,
  input  logic        wd_ready,
  output logic [31:0] wd_data,
  output logic        wd_last,
  output logic        frame_done
);
  localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   LW        = AW + 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_BURST = LW'(BURST_BEATS);
  localparam logic [7:0]    LEN_FULL  = 8'(BURST_BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state_q, state_n;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [LW-1:0] wptr_q, rptr_q, level, eof_lvl_q, avail;
  logic          full, empty, accept, complete, push, pop;
  logic [1:0]    byte_idx_q, idx;
  logic [23:0]   acc_q;
  logic [31:0]   word_c;
  logic [31:0]   addr_q;
  logic [7:0]    len_q, beat_q;
  logic          flush_q, eof_pend_q, sof_pend_q, frame_done_q;
  logic          load_req, idle_done, sof_apply, last_beat;

  assign level     = wptr_q - rptr_q;
  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign pix_ready = !ARESET && !full;
  assign accept    = pix_valid && pix_ready;
  assign idx       = pix_sof ? 2'd0 : byte_idx_q;
  assign complete  = (idx == 2'd3) || pix_eol || pix_eof;
  assign push      = accept && complete;

  // Bytes above the current pixel stay zero, which pads short eol/eof words.
  always_comb begin
    word_c = '0;
    for (int k = 0; k < 3; k++)
      if (k < int'(idx)) word_c[8*k +: 8] = acc_q[8*k +: 8];
    word_c[{idx, 3'b000} +: 8] = pix_data;
  end

  assign wd_valid   = (state_q == DATA) && !empty;
  assign wd_data    = wd_valid ? mem[rptr_q[AW-1:0]] : '0;
  assign wd_last    = wd_valid && (beat_q == len_q);
  assign pop        = wd_valid && wd_ready;
  assign bq_valid   = (state_q == REQ);
  assign bq_addr    = addr_q;
  assign bq_len     = len_q;
  assign frame_done = frame_done_q;

  // Once EOF is seen only the words of that frame count toward the next burst.
  assign avail = eof_pend_q ? eof_lvl_q : level;

  always_comb begin
    state_n   = state_q;
    load_req  = 1'b0;
    idle_done = 1'b0;
    sof_apply = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof_pend_q && !eof_pend_q) begin
          sof_apply = 1'b1;
        end else if (avail >= LVL_BURST || (eof_pend_q && avail != '0)) begin
          state_n  = REQ;
          load_req = 1'b1;
        end else if (eof_pend_q) begin
          idle_done = 1'b1;
        end
      end
      REQ: begin
        if (bq_ready) state_n = DATA;
      end
      DATA: begin
        if (pop && beat_q == len_q) begin
          last_beat = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      byte_idx_q <= 2'd0;
      acc_q      <= '0;
    end else begin
      if (accept) begin
        byte_idx_q <= complete ? 2'd0 : idx + 2'd1;
        acc_q      <= word_c[23:0];
      end
      if (push) wptr_q <= wptr_q + LW'(1);
      if (pop)  rptr_q <= rptr_q + LW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wptr_q[AW-1:0]] <= word_c;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      len_q        <= 8'd0;
      beat_q       <= 8'd0;
      flush_q      <= 1'b0;
      eof_pend_q   <= 1'b0;
      eof_lvl_q    <= '0;
      sof_pend_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      frame_done_q <= idle_done || (last_beat && flush_q);
      if (load_req) begin
        len_q   <= (avail >= LVL_BURST) ? LEN_FULL : 8'(avail - LW'(1));
        flush_q <= eof_pend_q && (avail < LVL_BURST);
        beat_q  <= 8'd0;
      end else if (pop) begin
        beat_q <= beat_q + 8'd1;
      end
      if (last_beat) addr_q <= addr_q + (({24'd0, len_q} + 32'd1) << 2);
      if (sof_apply) begin
        addr_q     <= BASE_ADDR;
        sof_pend_q <= 1'b0;
      end
      if (accept && pix_sof) sof_pend_q <= 1'b1;
      if (idle_done || (last_beat && flush_q)) begin
        eof_pend_q <= 1'b0;
      end else if (pop && eof_pend_q && eof_lvl_q != '0) begin
        eof_lvl_q <= eof_lvl_q - LW'(1);
      end
      // The EOF word is the newest in the FIFO, so everything up to it is the tail.
      if (push && pix_eof) begin
        eof_pend_q <= 1'b1;
        eof_lvl_q  <= pop ? level : level + LW'(1);
      end
    end
  end
endmodule
